jtag_regs: RTL and testbench
============================

JTAG_REGS -- requirements
Module: jtag_regs

Interface
REQ-001 SHALL have parameter IR_W, default 4, instruction register width.
REQ-002 SHALL have parameter IDCODE_VAL, default 32'h1000_0A5B, device ID; bit 0 always 1.
REQ-003 SHALL have parameter USER_W, default 32, user data register width.
REQ-004 SHALL have port tck, input, 1, test clock; all state updates on rising edge.
REQ-005 SHALL have port trst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port tdi, input, 1, serial test data in.
REQ-007 SHALL have port state_in, input, 4, TAP state code: 0 TEST_LOGIC_RESET, 1 RUN_TEST_IDLE, 2 SELECT_DR, 3 CAPTURE_DR, 4 SHIFT_DR, 5 EXIT1_DR, 6 PAUSE_DR, 7 EXIT2_DR, 8 UPDATE_DR, 9 SELECT_IR, 10 CAPTURE_IR, 11 SHIFT_IR, 12 EXIT1_IR, 13 PAUSE_IR, 14 EXIT2_IR, 15 UPDATE_IR.
REQ-008 SHALL have port tdo, output, 1, serial test data out.
REQ-009 SHALL have port tdo_oe, output, 1, high while state_in is SHIFT_DR or SHIFT_IR.
REQ-010 SHALL have port ir_out, output, IR_W, current active instruction.
REQ-011 SHALL have port user_rdata, input, USER_W, value captured into USER DR.
REQ-012 SHALL have port user_wdata, output, USER_W, last USER DR value updated.
REQ-013 SHALL have port user_wr, output, 1, one-tck write strobe for user_wdata.

Function
REQ-014 SHALL decode instructions: 4'h1 IDCODE, 4'h2 USER, all-ones BYPASS; any other code selects BYPASS.
REQ-015 SHALL hold IR shift register ir_sr (IR_W bits) and active register ir (IR_W bits).
REQ-016 SHALL, on tck rise in CAPTURE_IR, load ir_sr with {0..0,2'b01}.
REQ-017 SHALL, on tck rise in SHIFT_IR, shift ir_sr right: ir_sr <= {tdi, ir_sr[IR_W-1:1]}.
REQ-018 SHALL, on tck rise in UPDATE_IR, load ir <= ir_sr; ir_out follows ir.
REQ-019 SHALL, on tck rise in TEST_LOGIC_RESET, load ir <= IDCODE (4'h1).
REQ-020 SHALL hold separate shift registers: bypass (1 bit), id_sr (32 bits), usr_sr (USER_W bits).
REQ-021 SHALL, on tck rise in CAPTURE_DR, load only the selected DR: bypass <= 0, id_sr <= IDCODE_VAL, usr_sr <= user_rdata.
REQ-022 SHALL, on tck rise in SHIFT_DR, shift only the selected DR right, tdi entering MSB.
REQ-023 SHALL leave all shift registers unchanged in PAUSE, EXIT1, EXIT2, SELECT and RUN_TEST_IDLE states.
REQ-024 SHALL, on tck rise in UPDATE_DR with USER selected, load user_wdata <= usr_sr and assert user_wr for exactly that one tck cycle.
REQ-025 SHALL keep user_wr low in UPDATE_DR with IDCODE or BYPASS selected; IDCODE DR is read-only.
REQ-026 SHALL drive tdo from ir_sr[0] in SHIFT_IR, selected DR bit 0 in SHIFT_DR, else 0.
REQ-027 SHALL treat an instruction change as effective only from the tck after UPDATE_IR; DR selection never changes mid-scan.
REQ-028 SHALL shift an unbounded bit count without error; excess bits fall off the LSB (wrap-through, no saturation).

Reset
REQ-029 SHALL, while trst low, asynchronously set ir=4'h1, ir_sr=0, bypass=0, id_sr=0, usr_sr=0, user_wdata=0, user_wr=0, tdo=0.
REQ-030 SHALL abort any scan on trst mid-shift; no user_wr is generated for the aborted scan.
REQ-031 SHALL resume operation on the first tck rise after trst deasserts.

Configuration
REQ-032 SHALL support macro JTAG_REGS_TDO_NEGEDGE_EN.
REQ-033 SHALL, with JTAG_REGS_TDO_NEGEDGE_EN defined, register tdo and tdo_oe on the falling edge of tck; both reset to 0 by trst.
REQ-034 SHALL, without JTAG_REGS_TDO_NEGEDGE_EN, drive tdo and tdo_oe combinationally from state_in and shift registers.

Verification
REQ-035 SHALL check: trst pulse, state 0->1, CAPTURE_DR, 32 SHIFT_DR clocks -> tdo serializes 32'h1000_0A5B LSB first, ir_out=4'h1.
REQ-036 SHALL check: IR scan shifting 4'h2 -> tdo shows 1,0,0,0 during shift; ir_out=4'h2 after UPDATE_IR.
REQ-037 SHALL check: USER selected, user_rdata=32'hCAFE_F00D, shift in 32'h1234_5678 -> tdo returns CAFEF00D LSB first; user_wdata=32'h1234_5678; user_wr high for one tck.
REQ-038 SHALL check: IR 4'h7 (undefined), DR shift of tdi pattern 1,0,1,1 -> tdo 0,1,0,1 (one-bit delay); user_wr stays 0.
REQ-039 SHALL check: trst low after 10 of 32 USER shift bits -> all registers at reset values, ir_out=4'h1, no user_wr.
REQ-040 SHALL check: PAUSE_DR for 5 tck mid-USER-scan, then EXIT2->SHIFT_DR -> shifted data continuous, no bit lost or duplicated.

Source files
------------

// File: rtl/jtag_regs.sv
// JTAG TAP data/instruction registers (IR, BYPASS, IDCODE, USER) driven by an external TAP state code.
// Optional macro JTAG_REGS_TDO_NEGEDGE_EN registers tdo/tdo_oe on the falling edge of tck.
module jtag_regs #(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5B,
  parameter int          USER_W     = 32
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              tdi,
  input  logic [3:0]        state_in,
  output logic              tdo,
  output logic              tdo_oe,
  output logic [IR_W-1:0]   ir_out,
  input  logic [USER_W-1:0] user_rdata,
  output logic [USER_W-1:0] user_wdata,
  output logic              user_wr
);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,  RUN_TEST_IDLE = 4'd1,  SELECT_DR = 4'd2,  CAPTURE_DR = 4'd3,
    SHIFT_DR         = 4'd4,  EXIT1_DR      = 4'd5,  PAUSE_DR  = 4'd6,  EXIT2_DR   = 4'd7,
    UPDATE_DR        = 4'd8,  SELECT_IR     = 4'd9,  CAPTURE_IR = 4'd10, SHIFT_IR  = 4'd11,
    EXIT1_IR         = 4'd12, PAUSE_IR      = 4'd13, EXIT2_IR   = 4'd14, UPDATE_IR = 4'd15
  } tap_state_e;

  localparam logic [IR_W-1:0] INS_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] INS_USER   = IR_W'(2);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);
  // IEEE 1149.1 requires the IDCODE LSB to be 1 regardless of the parameter
  localparam logic [31:0]     ID_CAP     = {IDCODE_VAL[31:1], 1'b1};

  tap_state_e         st;
  logic [IR_W-1:0]    ir, ir_sr;
  logic               bypass;
  logic [31:0]        id_sr;
  logic [USER_W-1:0]  usr_sr;
  logic               sel_id, sel_usr;
  logic               tdo_c, tdo_oe_c;

  assign st      = tap_state_e'(state_in);
  assign sel_id  = (ir == INS_IDCODE);
  assign sel_usr = (ir == INS_USER);
  assign ir_out  = ir;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir         <= INS_IDCODE;
      ir_sr      <= '0;
      bypass     <= 1'b0;
      id_sr      <= '0;
      usr_sr     <= '0;
      user_wdata <= '0;
      user_wr    <= 1'b0;
    end else begin
      user_wr <= 1'b0;
      case (st)
        TEST_LOGIC_RESET: ir <= INS_IDCODE;
        CAPTURE_IR:       ir_sr <= IR_CAPTURE;
        SHIFT_IR:         ir_sr <= {tdi, ir_sr[IR_W-1:1]};
        UPDATE_IR:        ir <= ir_sr;
        CAPTURE_DR: begin
          if (sel_id)       id_sr  <= ID_CAP;
          else if (sel_usr) usr_sr <= user_rdata;
          else              bypass <= 1'b0;
        end
        SHIFT_DR: begin
          if (sel_id)       id_sr  <= {tdi, id_sr[31:1]};
          else if (sel_usr) usr_sr <= {tdi, usr_sr[USER_W-1:1]};
          else              bypass <= tdi;
        end
        UPDATE_DR: begin
          if (sel_usr) begin
            user_wdata <= usr_sr;
            user_wr    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tdo_c = 1'b0;
    case (st)
      SHIFT_IR: tdo_c = ir_sr[0];
      SHIFT_DR: tdo_c = sel_id ? id_sr[0] : (sel_usr ? usr_sr[0] : bypass);
      default:  tdo_c = 1'b0;
    endcase
  end

  assign tdo_oe_c = (st == SHIFT_DR) || (st == SHIFT_IR);

`ifdef JTAG_REGS_TDO_NEGEDGE_EN
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else begin
      tdo    <= tdo_c;
      tdo_oe <= tdo_oe_c;
    end
  end
`else
  assign tdo    = tdo_c;
  assign tdo_oe = tdo_oe_c;
`endif

endmodule

// File: tb/tb_jtag_regs.sv
// Directed bench for jtag_regs: IDCODE, IR scan, USER read/write, bypass, pause, trst abort.
module tb_jtag_regs;

  localparam logic [3:0] S_TLR = 4'd0,  S_RTI = 4'd1,  S_SELDR = 4'd2,  S_CAPDR = 4'd3,
                         S_SHDR = 4'd4, S_EX1DR = 4'd5, S_PDR = 4'd6,  S_EX2DR = 4'd7,
                         S_UPDR = 4'd8, S_SELIR = 4'd9, S_CAPIR = 4'd10, S_SHIR = 4'd11,
                         S_EX1IR = 4'd12, S_UPIR = 4'd15;

  logic        tck = 1'b0;
  logic        trst, tdi;
  logic [3:0]  state_in;
  logic        tdo, tdo_oe, user_wr;
  logic [3:0]  ir_out;
  logic [31:0] user_rdata, user_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic t, o;

  jtag_regs dut (
    .tck(tck), .trst(trst), .tdi(tdi), .state_in(state_in),
    .tdo(tdo), .tdo_oe(tdo_oe), .ir_out(ir_out),
    .user_rdata(user_rdata), .user_wdata(user_wdata), .user_wr(user_wr)
  );

  always #5 tck = ~tck;

  // Entered and left at posedge+1; tdo/tdo_oe sampled just after the falling edge.
  task automatic tick(input logic [3:0] st, input logic b, output logic to, output logic oe);
    state_in = st;
    tdi      = b;
    @(negedge tck); #1;
    to = tdo;
    oe = tdo_oe;
    @(posedge tck); #1;
  endtask

  task automatic ir_scan(input logic [3:0] v, output logic [3:0] cap);
    tick(S_SELDR, 1'b0, t, o);
    tick(S_SELIR, 1'b0, t, o);
    tick(S_CAPIR, 1'b0, t, o);
    for (int i = 0; i < 4; i++) begin
      tick(S_SHIR, v[i], t, o);
      cap[i] = t;
    end
    tick(S_EX1IR, 1'b0, t, o);
    tick(S_UPIR, 1'b0, t, o);
    tick(S_RTI, 1'b0, t, o);
  endtask

  task automatic test_reset();
    trst = 1'b0; state_in = S_TLR; tdi = 1'b0; user_rdata = '0;
    repeat (2) @(posedge tck);
    #1;
    n_checks++; if (ir_out !== 4'h1) begin n_fail++; $display("FAIL reset_ir_out got %h exp 1", ir_out); end
    n_checks++; if (user_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", user_wdata); end
    n_checks++; if (user_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b exp 0", user_wr); end
    n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo got %b exp 0", tdo); end
    trst = 1'b1;
  endtask

  task automatic test_idcode();
    logic [31:0] cap;
    logic        oe0;
    tick(S_TLR, 1'b0, t, o);
    tick(S_RTI, 1'b0, t, o);
    n_checks++; if (ir_out !== 4'h1) begin n_fail++; $display("FAIL idcode_ir_out got %h exp 1", ir_out); end
    tick(S_SELDR, 1'b0, t, o);
    tick(S_CAPDR, 1'b0, t, o);
    oe0 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick(S_SHDR, 1'b1, t, o);
      cap[i] = t;
      if (i == 0) oe0 = o;
    end
    n_checks++; if (oe0 !== 1'b1) begin n_fail++; $display("FAIL idcode_oe_shift got %b exp 1", oe0); end
    tick(S_EX1DR, 1'b0, t, o);
    n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL idcode_oe_exit got %b exp 0", o); end
    tick(S_UPDR, 1'b0, t, o);
    n_checks++; if (user_wr !== 1'b0) begin n_fail++; $display("FAIL idcode_no_wr got %b exp 0", user_wr); end
    tick(S_RTI, 1'b0, t, o);
    n_checks++; if (cap !== 32'h1000_0A5B) begin n_fail++; $display("FAIL idcode_serial got %h exp 10000a5b", cap); end
  endtask

  task automatic test_ir_scan();
    logic [3:0] cap;
    ir_scan(4'h2, cap);
    n_checks++; if (cap !== 4'b0001) begin n_fail++; $display("FAIL ir_capture got %b exp 0001", cap); end
    n_checks++; if (ir_out !== 4'h2) begin n_fail++; $display("FAIL ir_update got %h exp 2", ir_out); end
  endtask

  task automatic test_user();
    logic [31:0] cap;
    logic [31:0] din;
    din = 32'h1234_5678;
    user_rdata = 32'hCAFE_F00D;
    tick(S_SELDR, 1'b0, t, o);
    tick(S_CAPDR, 1'b0, t, o);
    for (int i = 0; i < 32; i++) begin
      tick(S_SHDR, din[i], t, o);
      cap[i] = t;
    end
    tick(S_EX1DR, 1'b0, t, o);
    n_checks++; if (user_wr !== 1'b0) begin n_fail++; $display("FAIL user_wr_early got %b exp 0", user_wr); end
    tick(S_UPDR, 1'b0, t, o);
    n_checks++; if (user_wr !== 1'b1) begin n_fail++; $display("FAIL user_wr_pulse got %b exp 1", user_wr); end
    n_checks++; if (user_wdata !== din) begin n_fail++; $display("FAIL user_wdata got %h exp %h", user_wdata, din); end
    tick(S_RTI, 1'b0, t, o);
    n_checks++; if (user_wr !== 1'b0) begin n_fail++; $display("FAIL user_wr_one_cycle got %b exp 0", user_wr); end
    n_checks++; if (cap !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL user_readback got %h exp cafef00d", cap); end
  endtask

  task automatic test_bypass();
    logic [3:0] cap, pat;
    pat = 4'b1101;  // tdi order 1,0,1,1
    ir_scan(4'h7, cap);
    tick(S_SELDR, 1'b0, t, o);
    tick(S_CAPDR, 1'b0, t, o);
    for (int i = 0; i < 4; i++) begin
      tick(S_SHDR, pat[i], t, o);
      cap[i] = t;
    end
    n_checks++; if (cap !== 4'b1010) begin n_fail++; $display("FAIL bypass_delay got %b exp 1010", cap); end
    tick(S_EX1DR, 1'b0, t, o);
    tick(S_UPDR, 1'b0, t, o);
    n_checks++; if (user_wr !== 1'b0) begin n_fail++; $display("FAIL bypass_no_wr got %b exp 0", user_wr); end
    n_checks++; if (user_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_wdata_kept got %h exp 12345678", user_wdata); end
    tick(S_RTI, 1'b0, t, o);
  endtask

  task automatic test_pause();
    logic [31:0] cap, din;
    logic [3:0]  irc;
    logic        tp, op;
    din = 32'h0F1E_2D3C;
    user_rdata = 32'hA5C3_0F96;
    ir_scan(4'h2, irc);
    tick(S_SELDR, 1'b0, t, o);
    tick(S_CAPDR, 1'b0, t, o);
    for (int i = 0; i < 10; i++) begin
      tick(S_SHDR, din[i], t, o);
      cap[i] = t;
    end
    tick(S_EX1DR, 1'b1, t, o);
    tp = 1'b0; op = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(S_PDR, 1'b1, t, o);
      tp = tp | t; op = op | o;
    end
    n_checks++; if ({tp, op} !== 2'b00) begin n_fail++; $display("FAIL pause_quiet got tdo/oe %b exp 00", {tp, op}); end
    tick(S_EX2DR, 1'b1, t, o);
    for (int i = 10; i < 32; i++) begin
      tick(S_SHDR, din[i], t, o);
      cap[i] = t;
    end
    tick(S_EX1DR, 1'b0, t, o);
    tick(S_UPDR, 1'b0, t, o);
    n_checks++; if (user_wdata !== din) begin n_fail++; $display("FAIL pause_wdata got %h exp %h", user_wdata, din); end
    n_checks++; if (cap !== 32'hA5C3_0F96) begin n_fail++; $display("FAIL pause_readback got %h exp a5c30f96", cap); end
    tick(S_RTI, 1'b0, t, o);
  endtask

  task automatic test_trst_abort();
    logic [7:0] cap8;
    logic [3:0] cap4;
    logic       wr_seen;
    user_rdata = 32'hFFFF_FFFF;
    tick(S_SELDR, 1'b1, t, o);
    tick(S_CAPDR, 1'b1, t, o);
    for (int i = 0; i < 10; i++) tick(S_SHDR, 1'b1, t, o);
    trst = 1'b0;
    #1;
    n_checks++; if (ir_out !== 4'h1) begin n_fail++; $display("FAIL abort_ir_out got %h exp 1", ir_out); end
    n_checks++; if (user_wdata !== 32'h0) begin n_fail++; $display("FAIL abort_wdata got %h exp 0", user_wdata); end
    n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL abort_tdo got %b exp 0", tdo); end
    @(posedge tck); #1;
    wr_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(S_UPDR, 1'b1, t, o);
      wr_seen = wr_seen | user_wr;
    end
    n_checks++; if (wr_seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_wr got %b exp 0", wr_seen); end
    trst = 1'b1;
    tick(S_RTI, 1'b0, t, o);
    n_checks++; if (ir_out !== 4'h1) begin n_fail++; $display("FAIL abort_resume_ir got %h exp 1", ir_out); end
    // Shifting without a capture exposes the reset contents of each register.
    for (int i = 0; i < 4; i++) begin
      tick(S_SHIR, 1'b0, t, o);
      cap4[i] = t;
    end
    tick(S_EX1IR, 1'b0, t, o);
    tick(S_RTI, 1'b0, t, o);
    n_checks++; if (cap4 !== 4'b0000) begin n_fail++; $display("FAIL abort_ir_sr got %b exp 0000", cap4); end
    for (int i = 0; i < 8; i++) begin
      tick(S_SHDR, 1'b0, t, o);
      cap8[i] = t;
    end
    tick(S_EX1DR, 1'b0, t, o);
    tick(S_RTI, 1'b0, t, o);
    n_checks++; if (cap8 !== 8'h00) begin n_fail++; $display("FAIL abort_id_sr got %h exp 00", cap8); end
    ir_scan(4'h2, cap4);
    for (int i = 0; i < 8; i++) begin
      tick(S_SHDR, 1'b0, t, o);
      cap8[i] = t;
    end
    tick(S_EX1DR, 1'b0, t, o);
    tick(S_RTI, 1'b0, t, o);
    n_checks++; if (cap8 !== 8'h00) begin n_fail++; $display("FAIL abort_usr_sr got %h exp 00", cap8); end
    ir_scan(4'hF, cap4);
    tick(S_SHDR, 1'b0, t, o);
    n_checks++; if (t !== 1'b0) begin n_fail++; $display("FAIL abort_bypass got %b exp 0", t); end
    tick(S_EX1DR, 1'b0, t, o);
    tick(S_RTI, 1'b0, t, o);
    n_checks++; if ({user_wr, user_wdata} !== 33'h0) begin n_fail++; $display("FAIL abort_final_wr got %b/%h exp 0/0", user_wr, user_wdata); end
  endtask

  initial begin
    test_reset();
    @(posedge tck); #1;
    test_idcode();
    test_ir_scan();
    test_user();
    test_bypass();
    test_pause();
    test_trst_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
